// File: rtl/me_input_feeder.sv
// me_input_feeder: walks the reference search strips and the current block
// out of their SRAMs and streams them, row-aligned, into the ME input buffer.
// Read requests are issued one row per cycle. Request side-band flags ride a
// single delay stage alongside the SRAM latency, and the stream leaves
// through one more register.
module me_input_feeder #(
  parameter int BLK_ROWS = 16,
  parameter int SR_ROWS  = 32,
  parameter int STRIPS   = 4,
  parameter int REF_AW   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cur_rd_o,
  output logic [3:0]        cur_addr_o,
  input  logic [31:0]       cur_data_i,
  output logic              ref_rd_o,
  output logic [REF_AW-1:0] ref_addr_o,
  input  logic [63:0]       ref_data_i,
  output logic              en_o,
  output logic              first_o,
  output logic [31:0]       cur_o,
  output logic [63:0]       ref_o
);

  localparam int RW = (SR_ROWS > 1) ? $clog2(SR_ROWS) : 1;
  localparam int SW = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam logic [RW-1:0] ROW_LAST   = RW'(SR_ROWS - 1);
  localparam logic [SW-1:0] STRIP_LAST = SW'(STRIPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [SW-1:0]       strip_q, strip_d;
  logic                drn_q, drn_d;

  // Issue-stage registers: these are the SRAM request outputs.
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cur_rd_q, cur_rd_d;
  logic [3:0]          cur_addr_q, cur_addr_d;
  logic                ref_rd_q, ref_rd_d;
  logic [REF_AW-1:0]   ref_addr_q, ref_addr_d;
  logic                row0_q, row0_d;

  // Delay stage, lined up with the cycle the SRAM data is valid.
  logic                ref_vld_q, ref_vld_d;
  logic                cur_vld_q, cur_vld_d;
  logic                row0_dly_q, row0_dly_d;

  // Output stream registers.
  logic                en_q, en_d;
  logic                first_q, first_d;
  logic [31:0]         cur_q, cur_d;
  logic [63:0]         ref_q, ref_d;

  logic                issue;
  logic [31:0]         row_ext, strip_ext, addr_full;

  // Next state, counters, and the registered outputs derived from the next state.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    strip_d   = strip_q;
    drn_d     = drn_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          row_d   = '0;
          strip_d = '0;
        end
      end
      RUN: begin
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (strip_q == STRIP_LAST) begin
            state_d = DRAIN;
            strip_d = '0;
            drn_d   = 1'b0;
          end else begin
            strip_d = strip_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      DRAIN: begin
        // Two cycles, covering the SRAM and output register latency.
        if (drn_q) state_d = DONE;
        else       drn_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    issue      = (state_d == RUN);
    row_ext    = 32'(row_d);
    strip_ext  = 32'(strip_d);
    addr_full  = strip_ext * 32'(SR_ROWS) + row_ext;

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    ref_rd_d   = issue;
    ref_addr_d = issue ? addr_full[REF_AW-1:0] : '0;
    cur_rd_d   = issue && (row_ext < 32'(BLK_ROWS));
    cur_addr_d = cur_rd_d ? row_ext[3:0] : 4'd0;
    row0_d     = issue && (row_d == '0);

    ref_vld_d  = ref_rd_q;
    cur_vld_d  = cur_rd_q;
    row0_dly_d = row0_q;

    en_d       = ref_vld_q;
    first_d    = ref_vld_q && row0_dly_q;
    ref_d      = ref_vld_q ? ref_data_i : 64'd0;
    // Rows past the current block carry zeros in the cur lane.
    cur_d      = (ref_vld_q && cur_vld_q) ? cur_data_i : 32'd0;
  end

  // All state; a reset drops the in-flight pipeline so nothing further is streamed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      strip_q    <= '0;
      drn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cur_rd_q   <= 1'b0;
      cur_addr_q <= 4'd0;
      ref_rd_q   <= 1'b0;
      ref_addr_q <= '0;
      row0_q     <= 1'b0;
      ref_vld_q  <= 1'b0;
      cur_vld_q  <= 1'b0;
      row0_dly_q <= 1'b0;
      en_q       <= 1'b0;
      first_q    <= 1'b0;
      cur_q      <= 32'd0;
      ref_q      <= 64'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      strip_q    <= strip_d;
      drn_q      <= drn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cur_rd_q   <= cur_rd_d;
      cur_addr_q <= cur_addr_d;
      ref_rd_q   <= ref_rd_d;
      ref_addr_q <= ref_addr_d;
      row0_q     <= row0_d;
      ref_vld_q  <= ref_vld_d;
      cur_vld_q  <= cur_vld_d;
      row0_dly_q <= row0_dly_d;
      en_q       <= en_d;
      first_q    <= first_d;
      cur_q      <= cur_d;
      ref_q      <= ref_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cur_rd_o   = cur_rd_q;
  assign cur_addr_o = cur_addr_q;
  assign ref_rd_o   = ref_rd_q;
  assign ref_addr_o = ref_addr_q;
  assign en_o       = en_q;
  assign first_o    = first_q;
  assign cur_o      = cur_q;
  assign ref_o      = ref_q;

endmodule

// File: tb/tb_me_input_feeder.sv
// Bench for me_input_feeder: SRAM models with random contents, a scoreboard
// filled from the search rules at start time, and a negedge monitor.
module tb_me_input_feeder;
  localparam int BLK = 16;
  localparam int SR  = 32;
  localparam int ST  = 4;
  localparam int AW  = 7;
  localparam int N   = ST * SR;

  logic          clk = 1'b0;
  logic          rst, start_i;
  logic          busy_o, done_o, cur_rd_o, ref_rd_o, en_o, first_o;
  logic [3:0]    cur_addr_o;
  logic [AW-1:0] ref_addr_o;
  logic [31:0]   cur_data_i, cur_o;
  logic [63:0]   ref_data_i, ref_o;

  always #5 clk = ~clk;

  me_input_feeder #(.BLK_ROWS(BLK), .SR_ROWS(SR), .STRIPS(ST), .REF_AW(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .cur_rd_o(cur_rd_o), .cur_addr_o(cur_addr_o), .cur_data_i(cur_data_i),
    .ref_rd_o(ref_rd_o), .ref_addr_o(ref_addr_o), .ref_data_i(ref_data_i),
    .en_o(en_o), .first_o(first_o), .cur_o(cur_o), .ref_o(ref_o)
  );

  logic [31:0] cur_mem [BLK];
  logic [63:0] ref_mem [1 << AW];

  // SRAM models, 1-cycle latency, garbage on the bus when not read.
  always @(posedge clk) begin
    cur_data_i <= cur_rd_o ? cur_mem[cur_addr_o] : $urandom;
    ref_data_i <= ref_rd_o ? ref_mem[ref_addr_o] : {$urandom, $urandom};
  end

  typedef struct {
    bit          first;
    logic [31:0] cur;
    logic [63:0] rf;
  } exp_t;
  exp_t sb[$];

  int vectors = 0, errs = 0, cyc = 0, t0 = 0;
  bit mon_on = 0;
  int en_cnt, en_first, en_last, busy_cnt, busy_first, busy_last, rd_seen;
  int rd_rises[$];
  int done_cycs[$];
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_stats();
    en_cnt = 0; en_first = -1; en_last = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    rd_seen = 0;
    rd_rises.delete(); done_cycs.delete(); sb.delete();
  endtask

  // Expected stream of one search: strip by strip, row by row.
  task automatic push_search();
    exp_t e;
    for (int s = 0; s < ST; s++)
      for (int r = 0; r < SR; r++) begin
        e.first = (r == 0);
        e.cur   = (r < BLK) ? cur_mem[r] : 32'd0;
        e.rf    = ref_mem[(s * SR + r) % (1 << AW)];
        sb.push_back(e);
      end
  endtask

  task automatic fill_mems(input bit ramp);
    for (int k = 0; k < BLK; k++) cur_mem[k] = ramp ? 32'(k) : $urandom;
    for (int k = 0; k < (1 << AW); k++) ref_mem[k] = {$urandom, $urandom};
  endtask

  // Monitor: scoreboard pops on en_o, request-side and timing bookkeeping.
  always @(negedge clk) begin
    int rel;
    exp_t e;
    if (mon_on) begin
      rel = cyc - t0;
      if (en_o) begin
        en_cnt++;
        if (en_first < 0) en_first = rel;
        en_last = rel;
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("first_o", 64'(first_o), 64'(e.first));
          chk("cur_o", 64'(cur_o), 64'(e.cur));
          chk("ref_o", ref_o, e.rf);
        end
      end else begin
        chk("cur_o_idle", 64'(cur_o), 64'd0);
        chk("ref_o_idle", ref_o, 64'd0);
      end
      if (ref_rd_o) begin
        if (!prev_rd) rd_rises.push_back(rel);
        chk("ref_addr", 64'(ref_addr_o), 64'(rd_seen % N));
        chk("cur_rd", 64'(cur_rd_o), 64'((rd_seen % SR) < BLK));
        if (cur_rd_o) chk("cur_addr", 64'(cur_addr_o), 64'(rd_seen % SR));
        rd_seen++;
      end else begin
        chk("ref_addr_idle", 64'(ref_addr_o), 64'd0);
        chk("cur_rd_idle", 64'(cur_rd_o), 64'd0);
      end
      if (!cur_rd_o) chk("cur_addr_idle", 64'(cur_addr_o), 64'd0);
      prev_rd = ref_rd_o;
      if (done_o) done_cycs.push_back(rel);
      if (busy_o) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
    end
  end

  task automatic chk_list(input string nm, input int q[$], input int e0, input int e1, input int n);
    chk({nm, "_count"}, 64'(q.size()), 64'(n));
    if (q.size() > 0 && n > 0) chk({nm, "_0"}, 64'(q[0]), 64'(e0));
    if (q.size() > 1 && n > 1) chk({nm, "_1"}, 64'(q[1]), 64'(e1));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0;
    fill_mems(1'b1);
    step(3);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_rd", 64'({cur_rd_o, ref_rd_o}), 64'd0);
    chk("rst_addr", 64'({cur_addr_o, ref_addr_o}), 64'd0);
    chk("rst_en_first", 64'({en_o, first_o}), 64'd0);
    chk("rst_cur_o", 64'(cur_o), 64'd0);
    chk("rst_ref_o", ref_o, 64'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    step(2);

    // Single search, cur word k = k.
    clear_stats(); push_search();
    t0 = cyc; start_i = 1'b1;
    step(1); start_i = 1'b0;
    step(140);
    chk_list("A_rd_rise", rd_rises, 1, 0, 1);
    chk("A_rd_cnt", 64'(rd_seen), 64'(N));
    chk("A_en_first", 64'(en_first), 64'd3);
    chk("A_en_last", 64'(en_last), 64'(N + 2));
    chk("A_en_cnt", 64'(en_cnt), 64'(N));
    chk_list("A_done", done_cycs, N + 3, 0, 1);
    chk("A_busy_first", 64'(busy_first), 64'd1);
    chk("A_busy_last", 64'(busy_last), 64'(N + 3));
    chk("A_busy_cnt", 64'(busy_cnt), 64'(N + 3));
    chk("A_sb_left", 64'(sb.size()), 64'd0);
    step(3);

    // start_i held high across two searches; only the IDLE gap re-arms.
    fill_mems(1'b0);
    clear_stats(); push_search(); push_search();
    t0 = cyc; start_i = 1'b1;
    step(141); start_i = 1'b0;
    step(160);
    chk_list("B_rd_rise", rd_rises, 1, N + 5, 2);
    chk_list("B_done", done_cycs, N + 3, 2 * N + 7, 2);
    chk("B_en_cnt", 64'(en_cnt), 64'(2 * N));
    chk("B_busy_cnt", 64'(busy_cnt), 64'(2 * (N + 3)));
    chk("B_sb_left", 64'(sb.size()), 64'd0);
    step(3);

    // Reset in cycle 50 of a search, restart in cycle 53.
    fill_mems(1'b0);
    clear_stats(); push_search();
    t0 = cyc; start_i = 1'b1;
    step(1); start_i = 1'b0;
    step(49); rst = 1'b1;
    step(1); rst = 1'b0;
    step(1);
    chk("C_en_cnt_rst", 64'(en_cnt), 64'd48);
    chk("C_en_last_rst", 64'(en_last), 64'd50);
    chk("C_busy_after_rst", 64'(busy_o), 64'd0);
    chk("C_done_rst", 64'(done_cycs.size()), 64'd0);
    sb.delete(); rd_seen = 0;
    step(1);
    push_search();
    start_i = 1'b1;
    step(1); start_i = 1'b0;
    step(140);
    chk_list("C_rd_rise", rd_rises, 1, 54, 2);
    chk_list("C_done", done_cycs, 53 + N + 3, 0, 1);
    chk("C_en_cnt", 64'(en_cnt), 64'(48 + N));
    chk("C_en_last", 64'(en_last), 64'(53 + N + 2));
    chk("C_sb_left", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
